// File: rtl/seven_seg_pkg.sv
// Shared segment codes and sizing helpers for the multiplexed seven-segment drivers.
package seven_seg_pkg;

   localparam int MAX_DIGITS = 8;

   // Active-low cathode patterns, bit order G..A.
   localparam logic [6:0] SEG_0   = 7'h40;
   localparam logic [6:0] SEG_1   = 7'h79;
   localparam logic [6:0] SEG_2   = 7'h24;
   localparam logic [6:0] SEG_3   = 7'h30;
   localparam logic [6:0] SEG_4   = 7'h19;
   localparam logic [6:0] SEG_5   = 7'h12;
   localparam logic [6:0] SEG_6   = 7'h02;
   localparam logic [6:0] SEG_7   = 7'h78;
   localparam logic [6:0] SEG_8   = 7'h00;
   localparam logic [6:0] SEG_9   = 7'h10;
   localparam logic [6:0] SEG_A   = 7'h08;
   localparam logic [6:0] SEG_B   = 7'h03;
   localparam logic [6:0] SEG_C   = 7'h46;
   localparam logic [6:0] SEG_D   = 7'h21;
   localparam logic [6:0] SEG_E   = 7'h06;
   localparam logic [6:0] SEG_F   = 7'h0E;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment cathode decoder.
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   always_comb begin
      // NOTE: default assigned first so every path drives seg_o and no latch is inferred.
      seg_o = SEG_OFF;
      case (hex_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = SEG_A;
         4'hB: seg_o = SEG_B;
         4'hC: seg_o = SEG_C;
         4'hD: seg_o = SEG_D;
         4'hE: seg_o = SEG_E;
         4'hF: seg_o = SEG_F;
      endcase
   end

endmodule

// File: rtl/seven_seg_mux_n.sv
// N-digit multiplexed seven-segment driver with frame latching, blanking,
// leading-zero suppression, PWM brightness and a dead cycle between digits.
module seven_seg_mux_n
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 25000,
   parameter int PWM_BITS   = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] hex_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_suppress,
   input  logic [PWM_BITS-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   anodes,
   output logic [6:0]              segs,
   output logic                    decimalPt,
   output logic                    frame_start
);

   localparam int PW = clog2(TICK_DIV);
   localparam int IW = clog2(NUM_DIGITS);
   localparam int LW = PW + PWM_BITS + 1;

   localparam logic [PW-1:0]         PRESC_LAST  = PW'(TICK_DIV - 1);
   localparam logic [IW-1:0]         IDX_LAST    = IW'(NUM_DIGITS - 1);
   localparam logic [LW-1:0]         TICK_DIV_W  = LW'(TICK_DIV);
   localparam logic [NUM_DIGITS-1:0] ANODES_IDLE = ANODES_OFF[NUM_DIGITS-1:0];

   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] hex;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   blank;
      logic                    lz;
   } snap_t;

   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   snap_t                 snap_q, snap_d;
   logic                  frame_start_q, frame_start_d;
   logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
   logic [6:0]            segs_q, segs_d;
   logic                  dp_q, dp_d;

   logic                  tick, wrap;
   logic [LW-1:0]         on_limit, presc_w;
   logic                  in_window;
   logic [NUM_DIGITS-1:0] zeros_from;
   logic                  suppress;
   logic [3:0]            cur_hex;
   logic [6:0]            seg_code;

   // Slot sequencing; the frame snapshot is taken on the tick that returns to digit 0.
   always_comb begin
      tick          = (presc_q == PRESC_LAST);
      wrap          = tick && (idx_q == IDX_LAST);
      presc_d       = tick ? '0 : presc_q + PW'(1);
      idx_d         = idx_q;
      if (wrap)      idx_d = '0;
      else if (tick) idx_d = idx_q + IW'(1);
      snap_d        = snap_q;
      if (wrap) snap_d = '{hex: hex_in, dp: dp_in, blank: blank_in, lz: lz_suppress};
      frame_start_d = wrap;
   end

   assign on_limit  = ((LW'(brightness) + LW'(1)) * TICK_DIV_W) >> PWM_BITS;
   assign presc_w   = LW'(presc_q);
   assign in_window = (presc_w != '0) && (presc_w <= on_limit);

   always_comb begin
      logic all_zero;
      all_zero   = 1'b1;
      zeros_from = '0;
      for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
         all_zero      = all_zero && (snap_q.hex[4*j +: 4] == 4'h0);
         zeros_from[j] = all_zero;
      end
   end

   assign suppress = snap_q.lz && (idx_q != '0) && zeros_from[idx_q];
   assign cur_hex  = snap_q.hex[4*idx_q +: 4];

   hex_to_seg u_dec (
      .hex_i (cur_hex),
      .seg_o (seg_code)
   );

   always_comb begin
      anodes_d = ANODES_IDLE;
      segs_d   = SEG_OFF;
      dp_d     = 1'b1;
      if (en && in_window && !snap_q.blank[idx_q] && !suppress) begin
         anodes_d = ANODES_IDLE & ~(NUM_DIGITS'(1) << idx_q);
         segs_d   = seg_code;
         dp_d     = ~snap_q.dp[idx_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q       <= '0;
         idx_q         <= '0;
         // NOTE: snapshot is reset so the first frame after reset shows the all-zero picture.
         snap_q        <= '0;
         frame_start_q <= 1'b0;
         anodes_q      <= ANODES_IDLE;
         segs_q        <= SEG_OFF;
         dp_q          <= 1'b1;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values of the others.
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         snap_q        <= snap_d;
         frame_start_q <= frame_start_d;
         anodes_q      <= anodes_d;
         segs_q        <= segs_d;
         dp_q          <= dp_d;
      end
   end

   assign anodes      = anodes_q;
   assign segs        = segs_q;
   assign decimalPt   = dp_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// Self-checking bench: cycle-indexed reference model of the display scan against seven_seg_mux_n.
`timescale 1ns/1ps
module tb_seven_seg_mux_n;

   localparam int ND    = 4;
   localparam int TD    = 4;
   localparam int PB    = 2;
   localparam int FRAME = ND * TD;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            en;
   logic [4*ND-1:0] hex_in;
   logic [ND-1:0]   dp_in;
   logic [ND-1:0]   blank_in;
   logic            lz_suppress;
   logic [PB-1:0]   brightness;
   logic [ND-1:0]   anodes;
   logic [6:0]      segs;
   logic            decimalPt;
   logic            frame_start;

   int n_checks = 0;
   int n_fail   = 0;
   int k        = 0;
   int fs_seen  = 0;

   logic [4*ND-1:0] snap_hex;
   logic [ND-1:0]   snap_dp;
   logic [ND-1:0]   snap_blank;
   logic            snap_lz;

   logic [6:0] seg_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seven_seg_mux_n #(
      .NUM_DIGITS (ND),
      .TICK_DIV   (TD),
      .PWM_BITS   (PB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .hex_in      (hex_in),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
      .lz_suppress (lz_suppress),
      .brightness  (brightness),
      .anodes      (anodes),
      .segs        (segs),
      .decimalPt   (decimalPt),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t (k=%0d)", tag, got, exp, $time, k);
      end
   endtask

   // One clock: the edge with index k renders the slot position k implies from the current snapshot.
   task automatic step();
      int          presc, slot, digit, limit;
      bit          lit;
      logic [ND-1:0] exp_an;
      logic [6:0]    exp_segs;
      logic          exp_dp, exp_fs;
      @(posedge clk);
      presc = k % TD;
      slot  = (k / TD) % ND;
      digit = int'((snap_hex >> (4 * slot)) & 16'hF);
      limit = ((int'(brightness) + 1) * TD) >> PB;
      lit   = en && (presc >= 1) && (presc <= limit) && !snap_blank[slot]
              && !(snap_lz && (slot != 0) && ((snap_hex >> (4 * slot)) == 0));
      exp_an   = lit ? ~(ND'(1) << slot) : '1;
      exp_segs = lit ? seg_table[digit] : 7'h7F;
      exp_dp   = lit ? ~snap_dp[slot] : 1'b1;
      exp_fs   = ((k % FRAME) == FRAME - 1);
      if (exp_fs) begin
         snap_hex   = hex_in;
         snap_dp    = dp_in;
         snap_blank = blank_in;
         snap_lz    = lz_suppress;
      end
      k++;
      @(negedge clk);
      check("anodes", 32'(anodes), 32'(exp_an));
      check("segs", 32'(segs), 32'(exp_segs));
      check("decimalPt", 32'(decimalPt), 32'(exp_dp));
      check("frame_start", 32'(frame_start), 32'(exp_fs));
      if (frame_start) fs_seen++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_anodes"}, 32'(anodes), 32'hF);
      check({tag, "_segs"}, 32'(segs), 32'h7F);
      check({tag, "_dp"}, 32'(decimalPt), 32'h1);
      check({tag, "_fs"}, 32'(frame_start), 32'h0);
   endtask

   // Asserts reset between clock edges and checks outputs before any edge arrives.
   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check_reset_outputs(tag);
      repeat (2) @(negedge clk);
      check_reset_outputs({tag, "_hold"});
      rst_n      = 1'b1;
      k          = 0;
      snap_hex   = '0;
      snap_dp    = '0;
      snap_blank = '0;
      snap_lz    = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b1;
      en          = 1'b1;
      hex_in      = 16'h1234;
      dp_in       = '0;
      blank_in    = '0;
      lz_suppress = 1'b0;
      brightness  = 2'd3;
      #2;
      apply_reset("reset");

      // Zero snapshot frame, then 4,3,2,1 scan.
      run(2 * FRAME);

      // Frame latch: change in the middle of slot 2.
      while ((k % FRAME) != 10) step();
      hex_in  = 16'hABCD;
      fs_seen = 0;
      run(2 * FRAME);
      check("fs_count", 32'(fs_seen), 32'd2);

      // Leading-zero suppression.
      hex_in      = 16'h0050;
      lz_suppress = 1'b1;
      run(2 * FRAME);
      hex_in = 16'h0000;
      run(2 * FRAME);

      // Minimum brightness, decimal point on digit 2, digit 0 blanked.
      hex_in      = 16'h1234;
      lz_suppress = 1'b0;
      brightness  = 2'd0;
      dp_in       = 4'b0100;
      blank_in    = 4'b0001;
      run(2 * FRAME);

      // Enable off mid-frame; frame_start keeps running.
      brightness = 2'd3;
      blank_in   = '0;
      run(5);
      en      = 1'b0;
      fs_seen = 0;
      run(2 * FRAME);
      check("fs_count_en_off", 32'(fs_seen), 32'd2);
      en = 1'b1;
      run(10);

      // Reset in the middle of a lit slot.
      while ((k % TD) != 2) step();
      check("pre_reset_lit", 32'(anodes != 4'hF), 32'd1);
      apply_reset("midreset");
      run(2 * FRAME);

      // Randomized traffic.
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            hex_in      = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            dp_in       = 4'($urandom);
            blank_in    = 4'($urandom) & 4'($urandom);
            lz_suppress = 1'($urandom_range(0, 1));
            brightness  = 2'($urandom);
            en          = ($urandom_range(0, 5) != 0);
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
